// File: rtl/alu_issue_unit.sv
// Initiator side of the ALU interface: accepts one command, drives the combinational ALU,
// waits a fixed settle time, captures result/flags and returns them; keeps the {V,C,Z} status.
module alu_issue_unit #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_setflg,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_ovfl,
    input  logic             alu_zero,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_r,
    output logic [2:0]       rsp_flags,
    output logic [2:0]       status,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state, next_state;
    logic [3:0] cnt;
    logic       setflg_q;
    logic       accept, capture, release_rsp;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        req_ready   = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        busy = (state != ST_IDLE);
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list;
    // state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            setflg_q  <= 1'b0;
            alu_op    <= 3'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            rsp_flags <= 3'd0;
            status    <= 3'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                alu_op   <= req_op;
                alu_a    <= req_a;
                alu_b    <= req_b;
                setflg_q <= req_setflg;
                cnt      <= CNT_LOAD;
            end else if (state == ST_SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Flags are packed {V,C,Z} both in the response and in the status register.
            if (capture) begin
                rsp_r     <= alu_r;
                rsp_flags <= {alu_ovfl, alu_cout, alu_zero};
                rsp_valid <= 1'b1;
                if (setflg_q)
                    status <= {alu_ovfl, alu_cout, alu_zero};
            end
            if (release_rsp)
                rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU (add / and / pass-A) on its outputs.
module tb_alu_issue_unit;

    localparam int WIDTH  = 16;
    localparam int SETTLE = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a, req_b;
    logic             req_setflg;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic             alu_ovfl, alu_zero, alu_cout;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_r;
    logic [2:0]       rsp_flags, status;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_unit #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_setflg(req_setflg),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_r(alu_r), .alu_ovfl(alu_ovfl), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_flags(rsp_flags), .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 3'b010 add, 3'b000 and, anything else passes A.
    always_comb begin
        logic [WIDTH:0] sum;
        sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_cout = 1'b0;
        alu_ovfl = 1'b0;
        case (alu_op)
            3'b010: begin
                alu_r    = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovfl = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'b000:  alu_r = alu_a & alu_b;
            default: alu_r = alu_a;
        endcase
        alu_zero = (alu_r == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic setflg);
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_setflg = setflg;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    // Bounded wait for rsp_valid; an expired budget is a failed comparison.
    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] held_r;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = '0;
        req_b      = '0;
        req_setflg = 1'b0;
        rsp_ready  = 1'b0;

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_status",    32'(status),    32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);

        // FFFF + FFFF with setflg: exact capture latency
        issue(3'b010, 16'hFFFF, 16'hFFFF, 1'b1);
        check("add1_busy",      32'(busy),      32'd1);
        check("add1_req_ready", 32'(req_ready), 32'd0);
        check("add1_alu_op",    32'(alu_op),    32'h2);
        check("add1_alu_b",     32'(alu_b),     32'hFFFF);
        for (int i = 1; i < SETTLE; i++) begin
            check("add1_early_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        check("add1_pre_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("add1_valid", 32'(rsp_valid), 32'd1);
        check("add1_r",     32'(rsp_r),     32'hFFFE);
        check("add1_flags", 32'(rsp_flags), 32'b010);
        check("add1_status", 32'(status),   32'b010);

        // Backpressure with a competing request held high
        held_r     = rsp_r;
        req_op     = 3'b000;
        req_a      = 16'h1234;
        req_b      = 16'h5678;
        req_setflg = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid",     32'(rsp_valid), 32'd1);
            check("bp_r",         32'(rsp_r),     32'(held_r));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_alu_a",     32'(alu_a),     32'hFFFF);
        end
        req_valid = 1'b0;
        drain();
        check("bp_rel_valid",  32'(rsp_valid), 32'd0);
        check("bp_rel_busy",   32'(busy),      32'd0);
        check("bp_rel_status", 32'(status),    32'b010);
        check("bp_rel_alu_op", 32'(alu_op),    32'h2);

        // Signed overflow without setflg
        issue(3'b010, 16'h7FFF, 16'h0001, 1'b0);
        wait_rsp("ovf");
        check("ovf_r",      32'(rsp_r),     32'h8000);
        check("ovf_flags",  32'(rsp_flags), 32'b100);
        check("ovf_status", 32'(status),    32'b010);
        drain();

        // Zero result with carry, setflg
        issue(3'b010, 16'h0001, 16'hFFFF, 1'b1);
        wait_rsp("zero");
        check("zero_r",      32'(rsp_r),     32'h0000);
        check("zero_flags",  32'(rsp_flags), 32'b011);
        check("zero_status", 32'(status),    32'b011);
        drain();

        // Non-add op through the pipe
        issue(3'b000, 16'hF0F0, 16'h3C3C, 1'b0);
        wait_rsp("and");
        check("and_r",     32'(rsp_r),     32'h3030);
        check("and_flags", 32'(rsp_flags), 32'b000);
        drain();

        // Reset while settling aborts the command
        issue(3'b010, 16'h0001, 16'h0001, 1'b1);
        tick();
        check("abort_pre_busy",   32'(busy),   32'd1);
        check("abort_pre_status", 32'(status), 32'b011);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy",   32'(busy),      32'd0);
        check("abort_ready",  32'(req_ready), 32'd1);
        check("abort_valid",  32'(rsp_valid), 32'd0);
        check("abort_status", 32'(status),    32'd0);
        check("abort_alu_a",  32'(alu_a),     32'd0);
        check("abort_alu_op", 32'(alu_op),    32'd0);
        for (int i = 0; i < SETTLE + 3; i++) begin
            tick();
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("abort_final_status", 32'(status), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
